// File: rtl/logic_unit_pkg.sv
// Shared definitions for the logic unit: op-code type and op-code constants.
package logic_unit_pkg;

    typedef logic [2:0] logic_op_t;

    localparam logic_op_t OP_AND  = 3'd0;
    localparam logic_op_t OP_OR   = 3'd1;
    localparam logic_op_t OP_NOT  = 3'd2;
    localparam logic_op_t OP_XOR  = 3'd3;
    localparam logic_op_t OP_NAND = 3'd4;
    localparam logic_op_t OP_NOR  = 3'd5;
    localparam logic_op_t OP_XNOR = 3'd6;
    localparam logic_op_t OP_PASS = 3'd7;

endpackage

// File: rtl/logic_unit_alu.sv
// Combinational bitwise logic unit: o_y = f(i_op, i_a, i_b) over WIDTH bits.
// Operand B is not used by NOT and PASS.
module logic_unit_alu
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_y
);

    // Select the bitwise function for the requested op-code.
    always_comb begin
        o_y = {WIDTH{1'b0}};
        case (logic_op_t'(i_op))
            OP_AND:  o_y = i_a & i_b;
            OP_OR:   o_y = i_a | i_b;
            OP_NOT:  o_y = ~i_a;
            OP_XOR:  o_y = i_a ^ i_b;
            OP_NAND: o_y = ~(i_a & i_b);
            OP_NOR:  o_y = ~(i_a | i_b);
            OP_XNOR: o_y = ~(i_a ^ i_b);
            OP_PASS: o_y = i_a;
            default: o_y = i_a;
        endcase
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// Registered logic unit with valid/ready handshakes on both sides, a
// one-deep output register and a saturating delivered-result counter.
// Optional feature macro LOGIC_UNIT_PIPE_FLAGS_EN adds registered
// out_zero / out_parity result flags.
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
`ifdef LOGIC_UNIT_PIPE_FLAGS_EN
    output logic             out_zero,
    output logic             out_parity,
`endif
    output logic [CNT_W-1:0] xfer_count
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] w_result;
    logic             w_accept;
    logic             w_deliver;

    logic_unit_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .i_op (in_op),
        .i_a  (in_a),
        .i_b  (in_b),
        .o_y  (w_result)
    );

    // The register can take a new result when empty or being drained now.
    assign in_ready  = !r_valid || out_ready;
    assign w_accept  = in_valid && in_ready;
    assign w_deliver = r_valid && out_ready;

    assign out_valid  = r_valid;
    assign out_data   = r_data;
    assign xfer_count = r_cnt;

    // Output register: load on accept, clear valid on a plain deliver.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= {WIDTH{1'b0}};
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_data  <= w_result;
        end else if (w_deliver) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= r_valid;
        end
    end

    // Delivered-result counter, held at all-ones once saturated.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (w_deliver && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

`ifdef LOGIC_UNIT_PIPE_FLAGS_EN
    logic r_zero;
    logic r_parity;

    function automatic logic parity_of(input logic [WIDTH-1:0] v);
        parity_of = ^v;
    endfunction

    assign out_zero   = r_zero;
    assign out_parity = r_parity;

    // Result flags follow out_data: captured only when a result is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_zero   <= 1'b0;
            r_parity <= 1'b0;
        end else if (w_accept) begin
            r_zero   <= (w_result == {WIDTH{1'b0}});
            r_parity <= parity_of(w_result);
        end else begin
            r_zero   <= r_zero;
            r_parity <= r_parity;
        end
    end
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe (WIDTH=8, CNT_W=4): directed
// scenarios plus randomized traffic against a queue-based reference model.
module tb_logic_unit_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic [2:0] in_op;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [3:0] xfer_count;
`ifdef LOGIC_UNIT_PIPE_FLAGS_EN
    logic       out_zero;
    logic       out_parity;
`endif

    logic_unit_pipe #(
        .WIDTH (8),
        .CNT_W (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
`ifdef LOGIC_UNIT_PIPE_FLAGS_EN
        .out_zero   (out_zero),
        .out_parity (out_parity),
`endif
        .xfer_count (xfer_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state.
    logic [7:0] q[$];
    int         exp_cnt  = 0;
    logic [7:0] exp_last = 8'h00;
    logic       exp_zf   = 1'b0;
    logic       exp_pf   = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Truth-table reference: bit i of the result from bits i of a and b.
    function automatic logic [7:0] ref_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            int x;
            int y;
            x = a[i] ? 1 : 0;
            y = b[i] ? 1 : 0;
            case (op)
                3'd0: r[i] = (x * y) == 1;
                3'd1: r[i] = (x + y) >= 1;
                3'd2: r[i] = (x == 0);
                3'd3: r[i] = (x + y) == 1;
                3'd4: r[i] = (x * y) == 0;
                3'd5: r[i] = (x + y) == 0;
                3'd6: r[i] = (x + y) != 1;
                default: r[i] = (x == 1);
            endcase
        end
        return r;
    endfunction

    function automatic logic odd_ones(input logic [7:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 8; i++) if (v[i]) n++;
        return (n % 2) == 1;
    endfunction

    // One clock cycle: drive inputs, check pre-edge state, advance model, check post-edge state.
    task automatic cycle(input logic v, input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic ordy, input logic r);
        logic       exp_rdy;
        logic       acc;
        logic       del;
        logic [7:0] res;
        in_valid  = v;
        in_op     = op;
        in_a      = a;
        in_b      = b;
        out_ready = ordy;
        rst       = r;
        #1;
        exp_rdy = (q.size() == 0) || ordy;
        check_eq("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
        check_eq("out_valid_pre", {31'd0, out_valid}, (q.size() != 0) ? 32'd1 : 32'd0);
        if (q.size() != 0) check_eq("out_data_pre", {24'd0, out_data}, {24'd0, q[0]});
        acc = v && exp_rdy;
        del = (q.size() != 0) && ordy;
        res = ref_op(op, a, b);
        @(posedge clk);
        #1;
        if (r) begin
            q.delete();
            exp_cnt  = 0;
            exp_last = 8'h00;
            exp_zf   = 1'b0;
            exp_pf   = 1'b0;
        end else begin
            if (del) begin
                void'(q.pop_front());
                if (exp_cnt < 15) exp_cnt++;
            end
            if (acc) begin
                q.push_back(res);
                exp_last = res;
                exp_zf   = (res == 8'h00);
                exp_pf   = odd_ones(res);
            end
        end
        check_eq("xfer_count", {28'd0, xfer_count}, exp_cnt);
        check_eq("out_valid", {31'd0, out_valid}, (q.size() != 0) ? 32'd1 : 32'd0);
        check_eq("out_data", {24'd0, out_data}, {24'd0, exp_last});
`ifdef LOGIC_UNIT_PIPE_FLAGS_EN
        check_eq("out_zero", {31'd0, out_zero}, {31'd0, exp_zf});
        check_eq("out_parity", {31'd0, out_parity}, {31'd0, exp_pf});
`endif
    endtask

    logic [7:0] sweep_exp [8];

    initial begin
        sweep_exp = '{8'h30, 8'hFC, 8'h0F, 8'hCC, 8'hCF, 8'h03, 8'h33, 8'hF0};
        in_valid  = 1'b0;
        in_op     = 3'd0;
        in_a      = 8'h00;
        in_b      = 8'h00;
        out_ready = 1'b0;
        rst       = 1'b1;
        // Bring the DUT out of its unknown power-up state.
        repeat (2) @(posedge clk);
        #1;

        // Reset held with in_valid=1: nothing is accepted.
        cycle(1'b1, 3'd1, 8'hAA, 8'h55, 1'b1, 1'b1);
        cycle(1'b1, 3'd1, 8'hAA, 8'h55, 1'b1, 1'b1);
        check_eq("reset_count", {28'd0, xfer_count}, 32'd0);
        check_eq("reset_data", {24'd0, out_data}, 32'd0);

        // Op sweep with a=0xF0, b=0x3C.
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 3'(i), 8'hF0, 8'h3C, 1'b1, 1'b0);
            check_eq("sweep_data", {24'd0, out_data}, {24'd0, sweep_exp[i]});
        end
        cycle(1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 1'b0);
        check_eq("sweep_count", {28'd0, xfer_count}, 32'd8);

        // Stall: AND held while XOR is offered.
        cycle(1'b1, 3'd0, 8'hFF, 8'h0F, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 3'd3, 8'hAA, 8'h55, 1'b0, 1'b0);
            check_eq("stall_data", {24'd0, out_data}, 32'h0F);
            check_eq("stall_ready", {31'd0, in_ready}, 32'd0);
        end
        cycle(1'b1, 3'd3, 8'hAA, 8'h55, 1'b1, 1'b0);
        check_eq("stall_xor", {24'd0, out_data}, 32'hFF);
        cycle(1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 1'b0);

        // Back-to-back traffic: counter saturates at 15.
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 1'b1, 1'b0);
            check_eq("b2b_valid", {31'd0, out_valid}, 32'd1);
        end
        check_eq("sat_count", {28'd0, xfer_count}, 32'd15);

        // Reset mid-stall discards the held result.
        cycle(1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 1'b0);
        cycle(1'b1, 3'd7, 8'h5C, 8'h00, 1'b0, 1'b0);
        cycle(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0);
        cycle(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b1);
        check_eq("rst_stall_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_stall_data", {24'd0, out_data}, 32'd0);
        cycle(1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 1'b0);
        check_eq("rst_stall_count", {28'd0, xfer_count}, 32'd0);

`ifdef LOGIC_UNIT_PIPE_FLAGS_EN
        cycle(1'b1, 3'd3, 8'h5A, 8'h5A, 1'b1, 1'b0);
        check_eq("flag_zero_xor", {31'd0, out_zero}, 32'd1);
        check_eq("flag_par_xor", {31'd0, out_parity}, 32'd0);
        cycle(1'b1, 3'd1, 8'h07, 8'h00, 1'b1, 1'b0);
        check_eq("flag_zero_or", {31'd0, out_zero}, 32'd0);
        check_eq("flag_par_or", {31'd0, out_parity}, 32'd1);
`endif

        // Randomized traffic with random backpressure and occasional reset.
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 60) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
